dmem_resp: RTL and testbench

- Data-memory responder on the far side of the execute-stage memory request interface.
- Accepts the read and write requests the execute stage issues (address, enable, store data, data type) and performs them on an internal synchronous word RAM.
- For loads, returns the sign- or zero-extended data to the write-back path.
- Asserts a stall toward the pipeline while a misaligned access is split across two RAM beats.

---
 rtl/dmem_resp.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_resp
//  Purpose  : Data-memory responder behind the execute-stage memory request
//             port. Performs byte/half/word loads and stores on an internal
//             word RAM and returns extended load data to write-back.
//  Option   : DMEM_MISALIGN_EN - when defined, misaligned accesses are split
//             into two RAM beats (SECOND state, stall_o raised). When
//             undefined, misaligned accesses are refused via misalign_o.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_mem_enable_i,
   input  logic [31:0] r_mem_addr_i,
   input  logic        w_mem_enable_i,
   input  logic [31:0] w_mem_addr_i,
   input  logic [31:0] w_mem_data_i,
   input  logic [2:0]  data_type_i,
   output logic [31:0] r_mem_data_o,
   output logic        r_mem_valid_o,
   output logic        stall_o,
   output logic        misalign_o
);

   // Sign/zero extension of a right-aligned load value by access type.
   function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] t);
      case (t)
         3'b001:  return {{24{v[7]}}, v[7:0]};
         3'b101:  return {24'd0, v[7:0]};
         3'b010:  return {{16{v[15]}}, v[15:0]};
         3'b110:  return {16'd0, v[15:0]};
         default: return v;
      endcase
   endfunction

   logic [31:0]   mem [DEPTH];

   logic          req_idle;
   logic [31:0]   req_addr;
   logic [1:0]    req_off;
   logic [AW-1:0] req_idx;
   logic [2:0]    req_size;
   logic [3:0]    req_mask;
   logic          req_misal;
   logic          req_wr;
   logic          req_rd;
   logic          unused_addr_hi;

   logic [3:0]    ram_we;
   logic [AW-1:0] ram_widx;
   logic [31:0]   ram_wdata;
   logic [AW-1:0] ram_ridx;
   logic [31:0]   ram_rdata;

   logic [31:0]   data_q, data_d;
   logic          valid_q, valid_d;

`ifdef DMEM_MISALIGN_EN
   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;
   state_t        state_q, state_d;
   logic          sec_wr_q, sec_wr_d;
   logic [3:0]    sec_be_q, sec_be_d;
   logic [31:0]   sec_wd_q, sec_wd_d;
   logic [AW-1:0] sec_idx_q, sec_idx_d;
   logic [31:0]   first_q, first_d;
   logic [1:0]    off_q, off_d;
   logic [2:0]    type_q, type_d;

   assign req_idle   = (state_q == IDLE);
   assign stall_o    = (state_q == SECOND);
   assign misalign_o = 1'b0;
`else
   logic          misal_q, misal_d;

   assign req_idle   = 1'b1;
   assign stall_o    = 1'b0;
   assign misalign_o = misal_q;
`endif

   // Address bits above the word index only wrap around the RAM.
   assign unused_addr_hi = ^req_addr[31:AW+2];
   assign ram_rdata      = mem[ram_ridx];
   assign r_mem_data_o   = data_q;
   assign r_mem_valid_o  = valid_q;

   // Decode the incoming request: store wins over load, type 000 is a no-op.
   always_comb begin
      req_addr = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
      req_off  = req_addr[1:0];
      req_idx  = req_addr[AW+1:2];
      case (data_type_i[1:0])
         2'b01:   begin req_size = 3'd1; req_mask = 4'b0001; end
         2'b10:   begin req_size = 3'd2; req_mask = 4'b0011; end
         2'b11:   begin req_size = 3'd4; req_mask = 4'b1111; end
         default: begin req_size = 3'd0; req_mask = 4'b0000; end
      endcase
      req_misal = (({1'b0, req_off} + req_size) > 3'd4);
      req_wr    = req_idle && w_mem_enable_i && (req_size != 3'd0);
      req_rd    = req_idle && !w_mem_enable_i && r_mem_enable_i && (req_size != 3'd0);
   end

   // RAM port control, load response and beat sequencing.
   always_comb begin
      ram_we    = 4'b0000;
      ram_widx  = req_idx;
      ram_wdata = w_mem_data_i << {req_off, 3'b000};
      ram_ridx  = req_idx;
      valid_d   = 1'b0;
      data_d    = data_q;
`ifdef DMEM_MISALIGN_EN
      state_d   = state_q;
      sec_wr_d  = sec_wr_q;
      sec_be_d  = sec_be_q;
      sec_wd_d  = sec_wd_q;
      sec_idx_d = sec_idx_q;
      first_d   = first_q;
      off_d     = off_q;
      type_d    = type_q;
      if (state_q == SECOND) begin
         state_d  = IDLE;
         ram_ridx = sec_idx_q;
         if (sec_wr_q) begin
            ram_we    = sec_be_q;
            ram_widx  = sec_idx_q;
            ram_wdata = sec_wd_q;
         end else begin
            // off_q is never 0 here, so the left shift stays below 32.
            valid_d = 1'b1;
            data_d  = extend((first_q >> {off_q, 3'b000}) |
                             (ram_rdata << (6'd32 - {1'b0, off_q, 3'b000})), type_q);
         end
      end else begin
         if (req_wr) begin
            ram_we = req_mask << req_off;
         end
         if (req_rd && !req_misal) begin
            valid_d = 1'b1;
            data_d  = extend(ram_rdata >> {req_off, 3'b000}, data_type_i);
         end
         if ((req_wr || req_rd) && req_misal) begin
            state_d   = SECOND;
            sec_wr_d  = req_wr;
            sec_be_d  = req_mask >> (3'd4 - {1'b0, req_off});
            sec_wd_d  = w_mem_data_i >> (6'd32 - {1'b0, req_off, 3'b000});
            sec_idx_d = req_idx + {{(AW-1){1'b0}}, 1'b1};
            first_d   = ram_rdata;
            off_d     = req_off;
            type_d    = data_type_i;
         end
      end
`else
      misal_d = 1'b0;
      if (req_wr && !req_misal) begin
         ram_we = req_mask << req_off;
      end
      if (req_rd && !req_misal) begin
         valid_d = 1'b1;
         data_d  = extend(ram_rdata >> {req_off, 3'b000}, data_type_i);
      end
      if ((req_wr || req_rd) && req_misal) begin
         misal_d = 1'b1;
      end
`endif
      // Reset abandons any pending beat; no RAM write under reset.
      if (rst) begin
         ram_we = 4'b0000;
      end
   end

   // Byte-lane RAM write; contents are not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we[b]) begin
            mem[ram_widx][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= 32'd0;
         valid_q <= 1'b0;
`ifdef DMEM_MISALIGN_EN
         state_q   <= IDLE;
         sec_wr_q  <= 1'b0;
         sec_be_q  <= 4'b0000;
         sec_wd_q  <= 32'd0;
         sec_idx_q <= '0;
         first_q   <= 32'd0;
         off_q     <= 2'd0;
         type_q    <= 3'd0;
`else
         misal_q <= 1'b0;
`endif
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef DMEM_MISALIGN_EN
         state_q   <= state_d;
         sec_wr_q  <= sec_wr_d;
         sec_be_q  <= sec_be_d;
         sec_wd_q  <= sec_wd_d;
         sec_idx_q <= sec_idx_d;
         first_q   <= first_d;
         off_q     <= off_d;
         type_q    <= type_d;
`else
         misal_q <= misal_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_resp
//  Purpose  : Directed self-checking bench for dmem_resp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_mem_enable_i;
   logic [31:0] r_mem_addr_i;
   logic        w_mem_enable_i;
   logic [31:0] w_mem_addr_i;
   logic [31:0] w_mem_data_i;
   logic [2:0]  data_type_i;
   logic [31:0] r_mem_data_o;
   logic        r_mem_valid_o;
   logic        stall_o;
   logic        misalign_o;

   int total = 0;
   int bad   = 0;

   localparam logic [2:0] T_BS = 3'b001, T_HS = 3'b010, T_W = 3'b011,
                          T_BU = 3'b101, T_HU = 3'b110, T_NONE = 3'b000;

   dmem_resp #(.DEPTH(1024), .AW(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .r_mem_enable_i (r_mem_enable_i),
      .r_mem_addr_i   (r_mem_addr_i),
      .w_mem_enable_i (w_mem_enable_i),
      .w_mem_addr_i   (w_mem_addr_i),
      .w_mem_data_i   (w_mem_data_i),
      .data_type_i    (data_type_i),
      .r_mem_data_o   (r_mem_data_o),
      .r_mem_valid_o  (r_mem_valid_o),
      .stall_o        (stall_o),
      .misalign_o     (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Store: the execute stage raises both enables.
   task automatic set_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      w_mem_enable_i = 1'b1; r_mem_enable_i = 1'b1;
      w_mem_addr_i = a; r_mem_addr_i = a; w_mem_data_i = d; data_type_i = t;
   endtask

   task automatic set_ld(input logic [31:0] a, input logic [2:0] t);
      w_mem_enable_i = 1'b0; r_mem_enable_i = 1'b1;
      r_mem_addr_i = a; w_mem_addr_i = 32'd0; w_mem_data_i = 32'd0; data_type_i = t;
   endtask

   task automatic clr;
      w_mem_enable_i = 1'b0; r_mem_enable_i = 1'b0;
      r_mem_addr_i = 32'd0; w_mem_addr_i = 32'd0; w_mem_data_i = 32'd0; data_type_i = T_NONE;
   endtask

   initial begin
      rst = 1'b1;
      clr();
      repeat (3) tick();
      chk("rst_data",  r_mem_data_o,  32'd0);
      chk("rst_valid", r_mem_valid_o, 1'b0);
      chk("rst_stall", stall_o,       1'b0);
      chk("rst_mis",   misalign_o,    1'b0);
      rst = 1'b0;
      tick();

      // Word store then word load.
      set_st(32'h10, 32'hDEADBEEF, T_W); tick(); clr();
      chk("st_no_valid", r_mem_valid_o, 1'b0);
      set_ld(32'h10, T_W); tick(); clr();
      chk("ldw_valid", r_mem_valid_o, 1'b1);
      chk("ldw_data",  r_mem_data_o,  32'hDEADBEEF);
      tick();
      chk("valid_pulse_end", r_mem_valid_o, 1'b0);
      chk("data_hold",       r_mem_data_o,  32'hDEADBEEF);

      // Sub-word extended loads.
      set_ld(32'h13, T_BS); tick(); clr();
      chk("ldbs_13", r_mem_data_o, 32'hFFFFFFDE);
      set_ld(32'h12, T_HU); tick(); clr();
      chk("ldhu_12", r_mem_data_o, 32'h0000DEAD);

      // Byte store with both enables, then word readback.
      set_st(32'h11, 32'h00000055, T_BS); tick(); clr();
      chk("stb_no_valid", r_mem_valid_o, 1'b0);
      set_ld(32'h10, T_W); tick(); clr();
      chk("ldw_after_stb", r_mem_data_o, 32'hDEAD55EF);

      // Back-to-back loads.
      set_ld(32'h12, T_HS); tick();
      chk("b2b_1_valid", r_mem_valid_o, 1'b1);
      chk("b2b_1_data",  r_mem_data_o,  32'hFFFFDEAD);
      set_ld(32'h12, T_BU); tick(); clr();
      chk("b2b_2_valid", r_mem_valid_o, 1'b1);
      chk("b2b_2_data",  r_mem_data_o,  32'h000000AD);

      // Type 000 is no access.
      set_ld(32'h10, T_NONE); tick(); clr();
      chk("noop_valid", r_mem_valid_o, 1'b0);

      // Upper address bits wrap onto the same word.
      set_ld(32'h00001010, T_W); tick(); clr();
      chk("addr_wrap", r_mem_data_o, 32'hDEAD55EF);

      // Store then immediate load of the same word.
      set_st(32'h20, 32'h01234567, T_W); tick();
      set_ld(32'h21, T_BU); tick(); clr();
      chk("st_then_ld", r_mem_data_o, 32'h00000045);

`ifdef DMEM_MISALIGN_EN
      chk("mis_tied", misalign_o, 1'b0);

      // Misaligned word store at 0x16.
      set_st(32'h16, 32'h11223344, T_W); tick();
      chk("mst_stall", stall_o, 1'b1);
      tick(); clr();
      chk("mst_stall_end", stall_o, 1'b0);
      chk("mst_no_valid",  r_mem_valid_o, 1'b0);

      // Misaligned word load at 0x16.
      set_ld(32'h16, T_W); tick();
      chk("mld_stall", stall_o, 1'b1);
      chk("mld_wait",  r_mem_valid_o, 1'b0);
      tick(); clr();
      chk("mld_stall_end", stall_o, 1'b0);
      chk("mld_valid",     r_mem_valid_o, 1'b1);
      chk("mld_data",      r_mem_data_o, 32'h11223344);

      // Lane placement of both beats.
      set_ld(32'h16, T_HU); tick(); clr();
      chk("w14_hi", r_mem_data_o, 32'h00003344);
      set_ld(32'h18, T_HU); tick(); clr();
      chk("w18_lo", r_mem_data_o, 32'h00001122);

      // Second beat wraps from word 1023 to word 0.
      set_st(32'hFFC, 32'hAAAABBBB, T_W); tick();
      set_st(32'h000, 32'hCCCCDDDD, T_W); tick();
      set_ld(32'hFFE, T_W); tick();
      chk("wrap_stall", stall_o, 1'b1);
      tick(); clr();
      chk("wrap_data", r_mem_data_o, 32'hDDDDAAAA);

      // Reset during SECOND abandons the load.
      set_ld(32'h16, T_W); tick();
      chk("rst2_stall", stall_o, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0; clr();
      chk("rst2_stall_clr", stall_o, 1'b0);
      chk("rst2_no_valid",  r_mem_valid_o, 1'b0);
      tick();
      chk("rst2_no_valid2", r_mem_valid_o, 1'b0);
      set_ld(32'h10, T_W); tick(); clr();
      chk("rst2_recover_valid", r_mem_valid_o, 1'b1);
      chk("rst2_recover_data",  r_mem_data_o,  32'hDEAD55EF);
`else
      // Misaligned load refused.
      set_ld(32'h3, T_HS); tick(); clr();
      chk("mis_ld_pulse", misalign_o,    1'b1);
      chk("mis_ld_novld", r_mem_valid_o, 1'b0);
      chk("mis_stall",    stall_o,       1'b0);
      tick();
      chk("mis_ld_pulse_end", misalign_o,    1'b0);
      chk("mis_ld_novld2",    r_mem_valid_o, 1'b0);

      // Misaligned store refused and leaves memory untouched.
      set_st(32'h11, 32'h99887766, T_W); tick(); clr();
      chk("mis_st_pulse", misalign_o, 1'b1);
      set_ld(32'h10, T_W); tick(); clr();
      chk("mis_st_nowrite", r_mem_data_o, 32'hDEAD55EF);
      chk("mis_after_ok",   misalign_o,   1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
